wb_arbiter: RTL

- Schedules writeback from the ALU and the load/store buffer onto one registered result bus (CDB) that feeds the reorder buffer, the reservation stations and the LSB.
- Each source has a small FIFO, so both units can finish in the same cycle without losing a result.
- Round-robin arbitration grants one broadcast per cycle.
- A flush on the pipeline `clear` discards every pending result.

---
 rtl/wb_arbiter_pkg.sv | 18 +
 rtl/wb_arbiter_fifo.sv | 58 +++++
 rtl/wb_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback constants: bus widths and CDB source encodings.
// The optional same-cycle bypass is enabled by defining WB_BYPASS_EN.
package wb_arbiter_pkg;

    localparam int ROBTagBus    = 5;
    localparam int ALUOutputBus = 32;
    localparam int LMDOutputBus = 32;
    localparam int AddrBus      = 32;

    localparam logic WB_SRC_ALU = 1'b0;
    localparam logic WB_SRC_LSB = 1'b1;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSB = 1'b1
    } rr_t;

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Circular result FIFO for one writeback source.
// Flush empties it; push into a full FIFO is dropped.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full && !i_flush;
    assign w_pop   = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + PW'(1);
            if (w_pop)
                r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wptr] <= i_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: ALU and LSB FIFOs onto one registered CDB.
// Define WB_BYPASS_EN to let a winning push skip its empty FIFO.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int TAG_WIDTH  = ROBTagBus,
    parameter int DATA_WIDTH = ALUOutputBus,
    parameter int ADDR_WIDTH = AddrBus,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear,
    input  logic                  alu_valid,
    input  logic [TAG_WIDTH-1:0]  alu_tag,
    input  logic [DATA_WIDTH-1:0] alu_value,
    input  logic [ADDR_WIDTH-1:0] alu_npc,
    output logic                  alu_full,
    input  logic                  lsb_valid,
    input  logic [TAG_WIDTH-1:0]  lsb_tag,
    input  logic [DATA_WIDTH-1:0] lsb_value,
    output logic                  lsb_full,
    output logic                  cdb_valid,
    output logic                  cdb_src,
    output logic [TAG_WIDTH-1:0]  cdb_tag,
    output logic [DATA_WIDTH-1:0] cdb_value,
    output logic [ADDR_WIDTH-1:0] cdb_npc
);

    localparam int EW = TAG_WIDTH + DATA_WIDTH + ADDR_WIDTH;

    rr_t           r_rr;
    logic          w_run;
    logic [EW-1:0] w_alu_in;
    logic [EW-1:0] w_lsb_in;
    logic [EW-1:0] w_alu_head;
    logic [EW-1:0] w_lsb_head;
    logic [EW-1:0] w_alu_src;
    logic [EW-1:0] w_lsb_src;
    logic [EW-1:0] w_sel;
    logic          w_alu_empty;
    logic          w_lsb_empty;
    logic          w_req_alu;
    logic          w_req_lsb;
    logic          w_byp_alu;
    logic          w_byp_lsb;
    logic          w_want_alu;
    logic          w_want_lsb;
    logic          w_gnt_alu;
    logic          w_gnt_lsb;

    assign w_run     = rdy_in && !clear;
    assign w_alu_in  = {alu_tag, alu_value, alu_npc};
    assign w_lsb_in  = {lsb_tag, lsb_value, {ADDR_WIDTH{1'b0}}};
    assign w_req_alu = !w_alu_empty;
    assign w_req_lsb = !w_lsb_empty;

`ifdef WB_BYPASS_EN
    assign w_byp_alu = w_alu_empty && alu_valid;
    assign w_byp_lsb = w_lsb_empty && lsb_valid;
`else
    assign w_byp_alu = 1'b0;
    assign w_byp_lsb = 1'b0;
`endif

    assign w_want_alu = w_req_alu || w_byp_alu;
    assign w_want_lsb = w_req_lsb || w_byp_lsb;
    assign w_gnt_alu  = w_want_alu && (!w_want_lsb || r_rr == RR_ALU);
    assign w_gnt_lsb  = w_want_lsb && !w_gnt_alu;

    // An empty FIFO can only be granted through the bypass path.
    assign w_alu_src = w_req_alu ? w_alu_head : w_alu_in;
    assign w_lsb_src = w_req_lsb ? w_lsb_head : w_lsb_in;
    assign w_sel     = w_gnt_alu ? w_alu_src : w_lsb_src;

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_flush (clear),
        .i_push  (w_run && alu_valid && !(w_gnt_alu && w_byp_alu)),
        .i_pop   (w_run && w_gnt_alu && w_req_alu),
        .i_data  (w_alu_in),
        .o_head  (w_alu_head),
        .o_empty (w_alu_empty),
        .o_full  (alu_full)
    );

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .i_clk   (clk_in),
        .i_rst   (rst_in),
        .i_flush (clear),
        .i_push  (w_run && lsb_valid && !(w_gnt_lsb && w_byp_lsb)),
        .i_pop   (w_run && w_gnt_lsb && w_req_lsb),
        .i_data  (w_lsb_in),
        .o_head  (w_lsb_head),
        .o_empty (w_lsb_empty),
        .o_full  (lsb_full)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_rr      <= RR_ALU;
            cdb_valid <= 1'b0;
            cdb_src   <= WB_SRC_ALU;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_npc   <= '0;
        end else if (clear) begin
            r_rr      <= RR_ALU;
            cdb_valid <= 1'b0;
        end else if (!rdy_in) begin
            cdb_valid <= 1'b0;
        end else if (w_gnt_alu || w_gnt_lsb) begin
            r_rr      <= w_gnt_alu ? RR_LSB : RR_ALU;
            cdb_valid <= 1'b1;
            cdb_src   <= w_gnt_alu ? WB_SRC_ALU : WB_SRC_LSB;
            cdb_tag   <= w_sel[EW-1 -: TAG_WIDTH];
            cdb_value <= w_sel[ADDR_WIDTH +: DATA_WIDTH];
            cdb_npc   <= w_sel[ADDR_WIDTH-1:0] & {ADDR_WIDTH{w_gnt_alu}};
        end else begin
            cdb_valid <= 1'b0;
        end
    end

endmodule
